// File: rtl/iq_pair_packer_pkg.sv
// Shared types and defaults for the I/Q pair packer.
package iq_pair_packer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_Q = 2'd2
  } pk_state_e;

  localparam int FIFO_DEPTH_DEF = 1024;
  localparam int HEADROOM_DEF   = 4;
  localparam int WRCNT_W        = 11;
  localparam int SKEW_TMR_W     = 8;

  // True while the FIFO can still take a word without eating into the headroom.
  function automatic logic fifo_has_room(input logic [WRCNT_W-1:0] level,
                                         input int depth, input int headroom);
    int lvl;
    lvl = int'(level);
    return lvl < (depth - headroom);
  endfunction

endpackage

// File: rtl/iq_pair_packer_sat_counter.sv
// Saturating statistics counter with synchronous clear taking priority over increment.
module sat_counter
  import iq_pair_packer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/iq_pair_packer.sv
// Pairs I and Q ADC samples under bounded strobe skew and writes {I,Q} words to the FIFO.
module iq_pair_packer
  import iq_pair_packer_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SKEW_MAX   = 8,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int HEADROOM   = HEADROOM_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  enable,
  input  logic                  clr_stats,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_valid,
  input  logic [DATA_W-1:0]     q_data,
  input  logic                  q_valid,
  input  logic [WRCNT_W-1:0]    fifo_wrcnt,
  output logic                  fifo_we,
  output logic [2*DATA_W-1:0]   fifo_data,
  output logic [CNT_W-1:0]      pair_cnt,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic [CNT_W-1:0]      skew_err_cnt
);

  // Last timer value at which a held sample may still meet its partner.
  localparam logic [SKEW_TMR_W-1:0] SKEW_LAST = SKEW_TMR_W'(SKEW_MAX - 1);

  pk_state_e               state_q, state_d;
  logic [DATA_W-1:0]       i_hold_q, i_hold_d;
  logic [DATA_W-1:0]       q_hold_q, q_hold_d;
  logic [SKEW_TMR_W-1:0]   timer_q, timer_d;
  logic                    fifo_we_q, fifo_we_d;
  logic [2*DATA_W-1:0]     fifo_data_q, fifo_data_d;

  logic                    pair_vld;
  logic [2*DATA_W-1:0]     pair_word;
  logic                    skew_err;
  logic                    pair_inc;
  logic                    drop_inc;

  // State, hold and output registers; reset drops any pending write.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= IDLE;
      i_hold_q    <= '0;
      q_hold_q    <= '0;
      timer_q     <= '0;
      fifo_we_q   <= 1'b0;
      fifo_data_q <= '0;
    end else begin
      state_q     <= state_d;
      i_hold_q    <= i_hold_d;
      q_hold_q    <= q_hold_d;
      timer_q     <= timer_d;
      fifo_we_q   <= fifo_we_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  // Pairing FSM: decides next state, captures, pair completion and skew errors.
  always_comb begin
    state_d   = state_q;
    i_hold_d  = i_hold_q;
    q_hold_d  = q_hold_q;
    timer_d   = timer_q;
    pair_vld  = 1'b0;
    pair_word = '0;
    skew_err  = 1'b0;
    if (!enable) begin
      // Flush silently: held samples are dropped without being counted.
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid && q_valid) begin
            pair_vld  = 1'b1;
            pair_word = {i_data, q_data};
          end else if (i_valid) begin
            i_hold_d = i_data;
            timer_d  = '0;
            state_d  = HOLD_I;
          end else if (q_valid) begin
            q_hold_d = q_data;
            timer_d  = '0;
            state_d  = HOLD_Q;
          end
        end
        HOLD_I: begin
          if (q_valid) begin
            pair_vld  = 1'b1;
            pair_word = {i_hold_q, q_data};
            if (i_valid) begin
              i_hold_d = i_data;
              timer_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else if (i_valid) begin
            skew_err = 1'b1;
            i_hold_d = i_data;
            timer_d  = '0;
          end else if (timer_q >= SKEW_LAST) begin
            skew_err = 1'b1;
            timer_d  = '0;
            state_d  = IDLE;
          end else begin
            timer_d = timer_q + SKEW_TMR_W'(1);
          end
        end
        HOLD_Q: begin
          if (i_valid) begin
            pair_vld  = 1'b1;
            pair_word = {i_data, q_hold_q};
            if (q_valid) begin
              q_hold_d = q_data;
              timer_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else if (q_valid) begin
            skew_err = 1'b1;
            q_hold_d = q_data;
            timer_d  = '0;
          end else if (timer_q >= SKEW_LAST) begin
            skew_err = 1'b1;
            timer_d  = '0;
            state_d  = IDLE;
          end else begin
            timer_d = timer_q + SKEW_TMR_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Output decode: a completed pair is written if the FIFO has room, else dropped.
  always_comb begin
    fifo_we_d   = 1'b0;
    fifo_data_d = fifo_data_q;
    pair_inc    = 1'b0;
    drop_inc    = 1'b0;
    if (pair_vld) begin
      if (fifo_has_room(fifo_wrcnt, FIFO_DEPTH, HEADROOM)) begin
        fifo_we_d   = 1'b1;
        fifo_data_d = pair_word;
        pair_inc    = 1'b1;
      end else begin
        drop_inc = 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_pair_cnt (
    .clk   (clk),
    .arstn (arstn),
    .inc   (pair_inc),
    .clr   (clr_stats),
    .cnt   (pair_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .arstn (arstn),
    .inc   (drop_inc),
    .clr   (clr_stats),
    .cnt   (drop_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_skew_err_cnt (
    .clk   (clk),
    .arstn (arstn),
    .inc   (skew_err),
    .clr   (clr_stats),
    .cnt   (skew_err_cnt)
  );

  assign fifo_we   = fifo_we_q;
  assign fifo_data = fifo_data_q;

endmodule

// File: tb/tb_iq_pair_packer.sv
// Directed bench for iq_pair_packer: pairing, skew, FIFO level, counters, enable and reset.
module tb_iq_pair_packer;

  logic        clk = 1'b0;
  logic        arstn;
  logic        enable;
  logic        clr_stats;
  logic [31:0] i_data;
  logic        i_valid;
  logic [31:0] q_data;
  logic        q_valid;
  logic [10:0] fifo_wrcnt;
  logic        fifo_we;
  logic [63:0] fifo_data;
  logic [15:0] pair_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] skew_err_cnt;

  // Narrow-counter copy sharing the same stimulus, used for saturation.
  logic        s_fifo_we;
  logic [63:0] s_fifo_data;
  logic [7:0]  s_pair_cnt;
  logic [7:0]  s_drop_cnt;
  logic [7:0]  s_skew_err_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iq_pair_packer #(
    .DATA_W(32), .SKEW_MAX(8), .FIFO_DEPTH(1024), .HEADROOM(4), .CNT_W(16)
  ) dut (
    .clk(clk), .arstn(arstn), .enable(enable), .clr_stats(clr_stats),
    .i_data(i_data), .i_valid(i_valid), .q_data(q_data), .q_valid(q_valid),
    .fifo_wrcnt(fifo_wrcnt), .fifo_we(fifo_we), .fifo_data(fifo_data),
    .pair_cnt(pair_cnt), .drop_cnt(drop_cnt), .skew_err_cnt(skew_err_cnt)
  );

  iq_pair_packer #(
    .DATA_W(32), .SKEW_MAX(8), .FIFO_DEPTH(1024), .HEADROOM(4), .CNT_W(8)
  ) u_sat (
    .clk(clk), .arstn(arstn), .enable(enable), .clr_stats(clr_stats),
    .i_data(i_data), .i_valid(i_valid), .q_data(q_data), .q_valid(q_valid),
    .fifo_wrcnt(fifo_wrcnt), .fifo_we(s_fifo_we), .fifo_data(s_fifo_data),
    .pair_cnt(s_pair_cnt), .drop_cnt(s_drop_cnt), .skew_err_cnt(s_skew_err_cnt)
  );

  // One clock cycle with the given strobes; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic iv, input logic [31:0] id, input logic qv, input logic [31:0] qd);
    i_valid = iv; i_data = id; q_valid = qv; q_data = qd;
    @(posedge clk); #1;
    i_valid = 1'b0; q_valid = 1'b0; clr_stats = 1'b0;
  endtask

  task automatic clear_stats();
    clr_stats = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    arstn = 1'b0; enable = 1'b0; clr_stats = 1'b0; fifo_wrcnt = 11'd0;
    i_valid = 1'b0; q_valid = 1'b0; i_data = '0; q_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (fifo_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", fifo_we); end
    checks++; if (fifo_data !== 64'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", fifo_data); end
    checks++; if (pair_cnt !== 16'h0) begin failures++; $display("FAIL reset_pair got=%0d exp=0", pair_cnt); end
    checks++; if (drop_cnt !== 16'h0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    checks++; if (skew_err_cnt !== 16'h0) begin failures++; $display("FAIL reset_skew got=%0d exp=0", skew_err_cnt); end
    arstn = 1'b1; enable = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_simultaneous();
    cyc(1'b1, 32'hA5A5_0001, 1'b1, 32'h5A5A_0002);
    checks++; if (fifo_we !== 1'b1) begin failures++; $display("FAIL simul_we got=%b exp=1", fifo_we); end
    checks++; if (fifo_data !== 64'hA5A5_0001_5A5A_0002) begin failures++; $display("FAIL simul_data got=%h exp=a5a500015a5a0002", fifo_data); end
    checks++; if (pair_cnt !== 16'd1) begin failures++; $display("FAIL simul_pair got=%0d exp=1", pair_cnt); end
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (fifo_we !== 1'b0) begin failures++; $display("FAIL simul_we_low got=%b exp=0", fifo_we); end
    checks++; if (fifo_data !== 64'hA5A5_0001_5A5A_0002) begin failures++; $display("FAIL simul_hold got=%h exp=a5a500015a5a0002", fifo_data); end
  endtask

  task automatic test_skew();
    int early;
    early = 0;
    clear_stats();
    cyc(1'b1, 32'h1111_0001, 1'b0, 32'h0);
    if (fifo_we !== 1'b0) early++;
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 32'h0, 1'b0, 32'h0);
      if (fifo_we !== 1'b0) early++;
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL skew_early_we got=%0d exp=0", early); end
    cyc(1'b0, 32'h0, 1'b1, 32'h2222_0002);
    checks++; if (fifo_we !== 1'b1) begin failures++; $display("FAIL skew_we got=%b exp=1", fifo_we); end
    checks++; if (fifo_data !== 64'h1111_0001_2222_0002) begin failures++; $display("FAIL skew_data got=%h exp=1111000122220002", fifo_data); end
    checks++; if (skew_err_cnt !== 16'd0) begin failures++; $display("FAIL skew_err got=%0d exp=0", skew_err_cnt); end
    checks++; if (pair_cnt !== 16'd1) begin failures++; $display("FAIL skew_pair got=%0d exp=1", pair_cnt); end
  endtask

  task automatic test_timeout();
    int wr;
    wr = 0;
    clear_stats();
    cyc(1'b1, 32'h3333_0003, 1'b0, 32'h0);
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, 32'h0, 1'b0, 32'h0);
      if (fifo_we !== 1'b0) wr++;
    end
    checks++; if (wr !== 0) begin failures++; $display("FAIL timeout_we got=%0d exp=0", wr); end
    checks++; if (skew_err_cnt !== 16'd1) begin failures++; $display("FAIL timeout_err got=%0d exp=1", skew_err_cnt); end
    cyc(1'b1, 32'h4444_0004, 1'b1, 32'h5555_0005);
    checks++; if (fifo_data !== 64'h4444_0004_5555_0005 || fifo_we !== 1'b1) begin
      failures++; $display("FAIL timeout_next got=%b/%h exp=1/4444000455550005", fifo_we, fifo_data);
    end
  endtask

  task automatic test_double_i();
    clear_stats();
    cyc(1'b1, 32'h6666_0006, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 32'h7777_0007, 1'b0, 32'h0);
    checks++; if (skew_err_cnt !== 16'd1) begin failures++; $display("FAIL dbl_err got=%0d exp=1", skew_err_cnt); end
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 32'h8888_0008);
    checks++; if (fifo_we !== 1'b1) begin failures++; $display("FAIL dbl_we got=%b exp=1", fifo_we); end
    checks++; if (fifo_data !== 64'h7777_0007_8888_0008) begin failures++; $display("FAIL dbl_data got=%h exp=7777000788880008", fifo_data); end
  endtask

  task automatic test_fifo_level();
    int wr;
    wr = 0;
    clear_stats();
    fifo_wrcnt = 11'd1020;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 32'h9000_0000 + k, 1'b1, 32'h9100_0000 + k);
      if (fifo_we !== 1'b0) wr++;
    end
    checks++; if (wr !== 0) begin failures++; $display("FAIL level_we got=%0d exp=0", wr); end
    checks++; if (drop_cnt !== 16'd3) begin failures++; $display("FAIL level_drop got=%0d exp=3", drop_cnt); end
    checks++; if (fifo_data !== 64'h7777_0007_8888_0008) begin failures++; $display("FAIL level_hold got=%h exp=7777000788880008", fifo_data); end
    fifo_wrcnt = 11'd1019;
    cyc(1'b1, 32'h9200_0001, 1'b1, 32'h9300_0001);
    checks++; if (fifo_we !== 1'b1 || fifo_data !== 64'h9200_0001_9300_0001) begin
      failures++; $display("FAIL level_write got=%b/%h exp=1/9200000193000001", fifo_we, fifo_data);
    end
    checks++; if (pair_cnt !== 16'd1 || drop_cnt !== 16'd3) begin
      failures++; $display("FAIL level_cnts got=%0d/%0d exp=1/3", pair_cnt, drop_cnt);
    end
    fifo_wrcnt = 11'd0;
  endtask

  task automatic test_back_to_back();
    int bad;
    logic [31:0] iv, qv;
    bad = 0;
    clear_stats();
    for (int k = 0; k < 260; k++) begin
      iv = 32'hB000_0000 | k;
      qv = 32'hC000_0000 | k;
      cyc(1'b1, iv, 1'b1, qv);
      if (fifo_we !== 1'b1 || fifo_data !== {iv, qv}) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_stream got=%0d bad exp=0", bad); end
    checks++; if (pair_cnt !== 16'd260) begin failures++; $display("FAIL b2b_pair got=%0d exp=260", pair_cnt); end
    checks++; if (s_pair_cnt !== 8'hFF) begin failures++; $display("FAIL sat_pair got=%h exp=ff", s_pair_cnt); end
    clr_stats = 1'b1;
    cyc(1'b1, 32'hD000_0001, 1'b1, 32'hD100_0001);
    checks++; if (pair_cnt !== 16'd0 || s_pair_cnt !== 8'd0) begin
      failures++; $display("FAIL clr_priority got=%0d/%0d exp=0/0", pair_cnt, s_pair_cnt);
    end
    checks++; if (fifo_we !== 1'b1) begin failures++; $display("FAIL clr_write got=%b exp=1", fifo_we); end
  endtask

  task automatic test_enable_drop();
    int wr;
    wr = 0;
    clear_stats();
    cyc(1'b0, 32'h0, 1'b1, 32'h9999_0009);
    enable = 1'b0;
    cyc(1'b1, 32'hAAAA_000A, 1'b0, 32'h0);
    if (fifo_we !== 1'b0) wr++;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 32'h0, 1'b0, 32'h0);
      if (fifo_we !== 1'b0) wr++;
    end
    checks++; if (wr !== 0) begin failures++; $display("FAIL en_we got=%0d exp=0", wr); end
    checks++; if (skew_err_cnt !== 16'd0 || pair_cnt !== 16'd0) begin
      failures++; $display("FAIL en_cnts got=%0d/%0d exp=0/0", skew_err_cnt, pair_cnt);
    end
    enable = 1'b1;
    cyc(1'b1, 32'hBBBB_000B, 1'b0, 32'h0);
    checks++; if (fifo_we !== 1'b0) begin failures++; $display("FAIL en_flushed got=%b exp=0", fifo_we); end
    cyc(1'b0, 32'h0, 1'b1, 32'hCCCC_000C);
    checks++; if (fifo_we !== 1'b1 || fifo_data !== 64'hBBBB_000B_CCCC_000C) begin
      failures++; $display("FAIL en_resume got=%b/%h exp=1/bbbb000bcccc000c", fifo_we, fifo_data);
    end
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 32'hD0D0_000D, 1'b1, 32'hE0E0_000E);
    arstn = 1'b0;
    #2;
    checks++; if (fifo_we !== 1'b0 || fifo_data !== 64'h0) begin
      failures++; $display("FAIL arst_out got=%b/%h exp=0/0", fifo_we, fifo_data);
    end
    checks++; if (pair_cnt !== 16'd0 || drop_cnt !== 16'd0 || skew_err_cnt !== 16'd0) begin
      failures++; $display("FAIL arst_cnts got=%0d/%0d/%0d exp=0/0/0", pair_cnt, drop_cnt, skew_err_cnt);
    end
    @(posedge clk); #1;
    arstn = 1'b1;
    cyc(1'b1, 32'hF0F0_000F, 1'b0, 32'h0);
    arstn = 1'b0;
    #2;
    arstn = 1'b1;
    cyc(1'b0, 32'h0, 1'b1, 32'h0E0E_0E0E);
    checks++; if (fifo_we !== 1'b0) begin failures++; $display("FAIL arst_hold got=%b exp=0", fifo_we); end
    cyc(1'b1, 32'h0D0D_0D0D, 1'b0, 32'h0);
    checks++; if (fifo_we !== 1'b1 || fifo_data !== 64'h0D0D_0D0D_0E0E_0E0E) begin
      failures++; $display("FAIL arst_after got=%b/%h exp=1/0d0d0d0d0e0e0e0e", fifo_we, fifo_data);
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_skew();
    test_timeout();
    test_double_i();
    test_fifo_level();
    test_back_to_back();
    test_enable_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
